// File: rtl/rob_alloc_ctrl_pkg.sv
// rob_alloc_ctrl_pkg
//   Shared types for the rename/ROB allocation path: the ROB size exponent,
//   the rename width, the sequence-number type and the branch-resolution
//   record broadcast by the branch unit.
package rob_alloc_ctrl_pkg;

  localparam int ROB_SIZE_EXP = 6;  // log2 of ROB entry count
  localparam int DEC_WIDTH    = 4;  // rename lanes per cycle

  // One extra bit beyond the ROB index so full and empty are distinguishable
  // and age comparisons can be done as signed differences.
  typedef logic [ROB_SIZE_EXP:0] SqN;

  typedef struct packed {
    logic taken;  // mispredict / flush redirect this cycle
    SqN   sqN;    // SqN of the offending instruction; younger ops are squashed
    logic flush;  // full pipeline flush
  } BranchProv;

endpackage

// File: rtl/rob_alloc_ctrl_lane_prefix_count.sv
// lane_prefix_count
//   Counts how many leading rename lanes can be allocated together: the run
//   of requesting lanes starting at lane 0, stopping at the first lane that
//   does not request or that carries a serializing op.
// Ports
//   req  - per-lane allocation request (contiguous from lane 0)
//   ser  - per-lane serialize flag
//   cnt  - number of lanes before the first gap or serializing lane
module lane_prefix_count #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] ser,
  output logic [CW-1:0]    cnt
);

  logic stop;

  always_comb begin
    cnt  = '0;
    stop = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!req[i] || ser[i]) stop = 1'b1;
      if (!stop) cnt = cnt + CW'(1);
    end
  end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// rob_alloc_ctrl
//   Hands out ROB sequence numbers to the rename lanes. Lanes are granted
//   all-or-nothing up to the first serializing op; a serializing op waits
//   for an empty ROB, is granted alone and then blocks further allocation
//   until it has committed. A branch redirect rewinds nextSqN and holds
//   allocation off until the rename-map replay finishes.
// Ports
//   clk, rst          - clock, synchronous active-high reset
//   IN_req            - lanes wanting a SqN (contiguous from lane 0)
//   IN_reqSerialize   - lane op must run alone on an empty ROB
//   IN_curSqN         - oldest uncommitted SqN (ROB base)
//   IN_maxSqN         - youngest allocatable SqN
//   IN_branch         - redirect record (taken, sqN, flush)
//   IN_mispredFlush   - rename-map replay in progress
//   OUT_grant         - lanes granted this cycle (combinational)
//   OUT_sqN           - SqN for each lane, nextSqN + lane
//   OUT_stall         - some requesting lane was not granted
//   OUT_free          - free ROB entries after this cycle's update (registered)
module rob_alloc_ctrl
  import rob_alloc_ctrl_pkg::*;
#(
  parameter int ID_LEN = ROB_SIZE_EXP,
  parameter int WIDTH  = DEC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            IN_req,
  input  logic [WIDTH-1:0]            IN_reqSerialize,
  input  logic [ID_LEN:0]             IN_curSqN,
  input  logic [ID_LEN:0]             IN_maxSqN,
  input  BranchProv                   IN_branch,
  input  logic                        IN_mispredFlush,
  output logic [WIDTH-1:0]            OUT_grant,
  output logic [WIDTH-1:0][ID_LEN:0]  OUT_sqN,
  output logic                        OUT_stall,
  output logic [ID_LEN:0]             OUT_free
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [ID_LEN:0] FREE_MAX = {1'b1, {ID_LEN{1'b0}}};

  typedef enum logic [2:0] {
    IDLE, SER_WAIT, SER_BLOCK, REPLAY_START, REPLAY_RUN
  } AllocState_t;

  AllocState_t     state;
  logic [ID_LEN:0] next_sqn;
  logic [ID_LEN:0] ser_sqn;
  logic [ID_LEN:0] branch_sqn;
  logic            ser_pending;

  logic [CW-1:0]   pre_cnt;
  logic [CW-1:0]   grant_cnt;
  logic [ID_LEN:0] br_sqn;
  logic [ID_LEN:0] free_now;
  logic [ID_LEN:0] next_d;
  logic [ID_LEN:0] free_raw;
  logic [ID_LEN:0] free_d;
  logic [ID_LEN:0] cur_minus_ser;
  logic [ID_LEN:0] ser_minus_br;
  logic            ser_head;
  logic            head_ready;
  logic            ser_done;
  logic            ser_survives;
  logic            unused_flush;

  assign unused_flush = IN_branch.flush;
  assign br_sqn       = (ID_LEN + 1)'(IN_branch.sqN);

  lane_prefix_count #(.WIDTH(WIDTH), .CW(CW)) u_prefix (
    .req (IN_req),
    .ser (IN_reqSerialize),
    .cnt (pre_cnt)
  );

  // Modulo arithmetic gives the right count across the SqN wrap.
  assign free_now = IN_maxSqN - next_sqn + (ID_LEN + 1)'(1);

  // A serializing op at the head only issues into an empty ROB.
  assign ser_head   = IN_req[0] & IN_reqSerialize[0];
  assign head_ready = ser_head && (IN_curSqN == next_sqn) && (free_now != '0);

  // Age tests as signed differences so they survive the SqN wrap:
  // ser_done     : curSqN strictly younger than serSqN (serializer committed)
  // ser_survives : serSqN not younger than the branch, so it was not squashed
  assign cur_minus_ser = IN_curSqN - ser_sqn;
  assign ser_minus_br  = ser_sqn - branch_sqn;
  assign ser_done      = !cur_minus_ser[ID_LEN] && (cur_minus_ser != '0);
  assign ser_survives  = ser_minus_br[ID_LEN] || (ser_minus_br == '0);

  always_comb begin
    grant_cnt = '0;
    if (!rst && !IN_branch.taken) begin
      case (state)
        IDLE: begin
          if (ser_head) begin
            if (head_ready) grant_cnt = CW'(1);
          end else if ((ID_LEN + 1)'(pre_cnt) <= free_now) begin
            grant_cnt = pre_cnt;
          end
        end
        SER_WAIT: if (head_ready) grant_cnt = CW'(1);
        default: grant_cnt = '0;
      endcase
    end
  end

  always_comb begin
    OUT_grant = '0;
    for (int i = 0; i < WIDTH; i++) begin
      OUT_grant[i] = (CW'(i) < grant_cnt);
      OUT_sqN[i]   = next_sqn + (ID_LEN + 1)'(i);
    end
  end

  assign OUT_stall = (|IN_req) && (OUT_grant != IN_req);

  always_comb begin
    next_d   = IN_branch.taken ? br_sqn + (ID_LEN + 1)'(1)
                               : next_sqn + (ID_LEN + 1)'(grant_cnt);
    free_raw = IN_maxSqN - next_d + (ID_LEN + 1)'(1);
    free_d   = (free_raw > FREE_MAX) ? FREE_MAX : free_raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      next_sqn    <= '0;
      ser_sqn     <= '0;
      branch_sqn  <= '0;
      ser_pending <= 1'b0;
      OUT_free    <= FREE_MAX;
    end else begin
      next_sqn <= next_d;
      OUT_free <= free_d;
      if (IN_branch.taken) begin
        // Redirect wins over everything, including a replay already running.
        state      <= REPLAY_START;
        branch_sqn <= br_sqn;
      end else begin
        case (state)
          IDLE, SER_WAIT: begin
            if (head_ready) begin
              state       <= SER_BLOCK;
              ser_sqn     <= next_sqn;
              ser_pending <= 1'b1;
            end else if (ser_head) begin
              state <= SER_WAIT;
            end else begin
              state <= IDLE;
            end
          end
          SER_BLOCK: begin
            if (ser_done) begin
              state       <= IDLE;
              ser_pending <= 1'b0;
            end
          end
          REPLAY_START: state <= REPLAY_RUN;
          REPLAY_RUN: begin
            if (!IN_mispredFlush) begin
              if (ser_pending && ser_survives) begin
                state <= SER_BLOCK;
              end else begin
                state       <= IDLE;
                ser_pending <= 1'b0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// tb_rob_alloc_ctrl
//   Scenario bench for rob_alloc_ctrl (ID_LEN=6, WIDTH=4). Each step drives
//   one cycle of inputs and pushes the hand-derived grant/stall plus model
//   SqNs onto a scoreboard; the entry is popped and compared mid-cycle.
module tb_rob_alloc_ctrl;
  import rob_alloc_ctrl_pkg::*;

  logic            clk;
  logic            rst;
  logic [3:0]      IN_req;
  logic [3:0]      IN_reqSerialize;
  logic [6:0]      IN_curSqN;
  logic [6:0]      IN_maxSqN;
  BranchProv       IN_branch;
  logic            IN_mispredFlush;
  logic [3:0]      OUT_grant;
  logic [3:0][6:0] OUT_sqN;
  logic            OUT_stall;
  logic [6:0]      OUT_free;

  rob_alloc_ctrl #(.ID_LEN(6), .WIDTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .IN_req          (IN_req),
    .IN_reqSerialize (IN_reqSerialize),
    .IN_curSqN       (IN_curSqN),
    .IN_maxSqN       (IN_maxSqN),
    .IN_branch       (IN_branch),
    .IN_mispredFlush (IN_mispredFlush),
    .OUT_grant       (OUT_grant),
    .OUT_sqN         (OUT_sqN),
    .OUT_stall       (OUT_stall),
    .OUT_free        (OUT_free)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] req;
    logic [3:0] ser;
    logic [6:0] cur;
    logic [6:0] mx;
    logic       fl;
    logic       bt;
    logic [6:0] bs;
    logic [3:0] eg;
    logic       es;
    logic       cf;
    logic [6:0] ef;
  } step_t;

  typedef struct {
    logic [3:0]      grant;
    logic            stall;
    logic [3:0][6:0] sqn;
  } exp_t;

  exp_t       sb[$];
  logic [6:0] model_next;
  int         n_chk;
  int         n_fail;

  function automatic step_t mk(logic r, logic [3:0] req, logic [3:0] ser,
                               logic [6:0] cur, logic [6:0] mx, logic fl,
                               logic bt, logic [6:0] bs, logic [3:0] eg,
                               logic es, logic cf, logic [6:0] ef);
    step_t s;
    s.r = r; s.req = req; s.ser = ser; s.cur = cur; s.mx = mx; s.fl = fl;
    s.bt = bt; s.bs = bs; s.eg = eg; s.es = es; s.cf = cf; s.ef = ef;
    return s;
  endfunction

  // Drive one cycle of stimulus and queue what the DUT should show for it.
  task automatic apply(input step_t s);
    exp_t e;
    rst             = s.r;
    IN_req          = s.req;
    IN_reqSerialize = s.ser;
    IN_curSqN       = s.cur;
    IN_maxSqN       = s.mx;
    IN_mispredFlush = s.fl;
    IN_branch       = '{taken: s.bt, sqN: s.bs, flush: 1'b0};
    e.grant = s.eg;
    e.stall = s.es;
    for (int i = 0; i < 4; i++) e.sqn[i] = model_next + 7'(i);
    sb.push_back(e);
    if (s.r)       model_next = 7'd0;
    else if (s.bt) model_next = s.bs + 7'd1;
    else           model_next = model_next + 7'($countones(s.eg));
  endtask

  task automatic test_reset();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(1, 4'b1111, 4'b0000, 7'd0, 7'd63, 0, 1, 7'd50, 4'b0000, 1, 1, 7'd64));
    st.push_back(mk(1, 4'b1111, 4'b0000, 7'd0, 7'd63, 0, 0, 7'd0,  4'b0000, 1, 1, 7'd64));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (OUT_grant !== e.grant) begin
        n_fail++; $display("FAIL reset[%0d] grant got %b want %b", i, OUT_grant, e.grant);
      end
      n_chk++;
      if (OUT_stall !== e.stall) begin
        n_fail++; $display("FAIL reset[%0d] stall got %b want %b", i, OUT_stall, e.stall);
      end
      @(posedge clk); #1;
      if (st[i].cf) begin
        n_chk++;
        if (OUT_free !== st[i].ef) begin
          n_fail++; $display("FAIL reset[%0d] free got %0d want %0d", i, OUT_free, st[i].ef);
        end
      end
    end
  endtask

  // Generic scenario runner body is repeated per test so each carries its
  // own name in the FAIL lines.
  task automatic test_basic();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd0, 7'd63, 0, 0, 7'd0, 4'b1111, 0, 1, 7'd60));
    st.push_back(mk(0, 4'b0000, 4'b0000, 7'd0, 7'd63, 0, 0, 7'd0, 4'b0000, 0, 1, 7'd60));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (OUT_grant !== e.grant) begin
        n_fail++; $display("FAIL basic[%0d] grant got %b want %b", i, OUT_grant, e.grant);
      end
      n_chk++;
      if (OUT_stall !== e.stall) begin
        n_fail++; $display("FAIL basic[%0d] stall got %b want %b", i, OUT_stall, e.stall);
      end
      for (int l = 0; l < 4; l++) if (e.grant[l]) begin
        n_chk++;
        if (OUT_sqN[l] !== e.sqn[l]) begin
          n_fail++; $display("FAIL basic[%0d] sqN%0d got %0d want %0d", i, l, OUT_sqN[l], e.sqn[l]);
        end
      end
      @(posedge clk); #1;
      if (st[i].cf) begin
        n_chk++;
        if (OUT_free !== st[i].ef) begin
          n_fail++; $display("FAIL basic[%0d] free got %0d want %0d", i, OUT_free, st[i].ef);
        end
      end
    end
  endtask

  task automatic test_full();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 4'b0000, 4'b0000, 7'd0, 7'd64, 0, 1, 7'd61, 4'b0000, 0, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd0, 7'd64, 0, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd0, 7'd64, 1, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd0, 7'd64, 0, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd0, 7'd64, 0, 0, 7'd0,  4'b0000, 1, 1, 7'd3));
    st.push_back(mk(0, 4'b0111, 4'b0000, 7'd0, 7'd64, 0, 0, 7'd0,  4'b0111, 0, 1, 7'd0));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (OUT_grant !== e.grant) begin
        n_fail++; $display("FAIL full[%0d] grant got %b want %b", i, OUT_grant, e.grant);
      end
      n_chk++;
      if (OUT_stall !== e.stall) begin
        n_fail++; $display("FAIL full[%0d] stall got %b want %b", i, OUT_stall, e.stall);
      end
      for (int l = 0; l < 4; l++) if (e.grant[l]) begin
        n_chk++;
        if (OUT_sqN[l] !== e.sqn[l]) begin
          n_fail++; $display("FAIL full[%0d] sqN%0d got %0d want %0d", i, l, OUT_sqN[l], e.sqn[l]);
        end
      end
      @(posedge clk); #1;
      if (st[i].cf) begin
        n_chk++;
        if (OUT_free !== st[i].ef) begin
          n_fail++; $display("FAIL full[%0d] free got %0d want %0d", i, OUT_free, st[i].ef);
        end
      end
    end
  endtask

  task automatic test_serialize();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 4'b0000, 4'b0000, 7'd7,  7'd73, 0, 1, 7'd9, 4'b0000, 0, 0, 7'd0));
    st.push_back(mk(0, 4'b0000, 4'b0000, 7'd7,  7'd73, 0, 0, 7'd0, 4'b0000, 0, 0, 7'd0));
    st.push_back(mk(0, 4'b0000, 4'b0000, 7'd7,  7'd73, 0, 0, 7'd0, 4'b0000, 0, 0, 7'd0));
    st.push_back(mk(0, 4'b0001, 4'b0001, 7'd7,  7'd73, 0, 0, 7'd0, 4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0001, 4'b0001, 7'd8,  7'd73, 0, 0, 7'd0, 4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0001, 4'b0001, 7'd9,  7'd73, 0, 0, 7'd0, 4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0001, 4'b0001, 7'd10, 7'd73, 0, 0, 7'd0, 4'b0001, 0, 1, 7'd63));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd10, 7'd73, 0, 0, 7'd0, 4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd10, 7'd73, 0, 0, 7'd0, 4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd11, 7'd73, 0, 0, 7'd0, 4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd11, 7'd73, 0, 0, 7'd0, 4'b1111, 0, 1, 7'd59));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (OUT_grant !== e.grant) begin
        n_fail++; $display("FAIL serialize[%0d] grant got %b want %b", i, OUT_grant, e.grant);
      end
      n_chk++;
      if (OUT_stall !== e.stall) begin
        n_fail++; $display("FAIL serialize[%0d] stall got %b want %b", i, OUT_stall, e.stall);
      end
      for (int l = 0; l < 4; l++) if (e.grant[l]) begin
        n_chk++;
        if (OUT_sqN[l] !== e.sqn[l]) begin
          n_fail++; $display("FAIL serialize[%0d] sqN%0d got %0d want %0d", i, l, OUT_sqN[l], e.sqn[l]);
        end
      end
      @(posedge clk); #1;
      if (st[i].cf) begin
        n_chk++;
        if (OUT_free !== st[i].ef) begin
          n_fail++; $display("FAIL serialize[%0d] free got %0d want %0d", i, OUT_free, st[i].ef);
        end
      end
    end
  endtask

  // Serialize on lane 2, then a redirect at the serializing op itself: the
  // op survives the replay so allocation must return to SER_BLOCK.
  task automatic test_ser_lane2();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 4'b1111, 4'b0100, 7'd11, 7'd73, 0, 0, 7'd0,  4'b0011, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0011, 4'b0001, 7'd11, 7'd73, 0, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0011, 4'b0001, 7'd17, 7'd73, 0, 0, 7'd0,  4'b0001, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0000, 4'b0000, 7'd17, 7'd73, 0, 1, 7'd17, 4'b0000, 0, 0, 7'd0));
    st.push_back(mk(0, 4'b0001, 4'b0000, 7'd17, 7'd73, 0, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0001, 4'b0000, 7'd17, 7'd73, 1, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0001, 4'b0000, 7'd17, 7'd73, 0, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0001, 4'b0000, 7'd17, 7'd73, 0, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0001, 4'b0000, 7'd18, 7'd73, 0, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0001, 4'b0000, 7'd18, 7'd73, 0, 0, 7'd0,  4'b0001, 0, 0, 7'd0));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (OUT_grant !== e.grant) begin
        n_fail++; $display("FAIL ser_lane2[%0d] grant got %b want %b", i, OUT_grant, e.grant);
      end
      n_chk++;
      if (OUT_stall !== e.stall) begin
        n_fail++; $display("FAIL ser_lane2[%0d] stall got %b want %b", i, OUT_stall, e.stall);
      end
      for (int l = 0; l < 4; l++) if (e.grant[l]) begin
        n_chk++;
        if (OUT_sqN[l] !== e.sqn[l]) begin
          n_fail++; $display("FAIL ser_lane2[%0d] sqN%0d got %0d want %0d", i, l, OUT_sqN[l], e.sqn[l]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  // Includes a second redirect during replay that must restart it.
  task automatic test_branch();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 0, 1, 7'd50, 4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 0, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 1, 1, 7'd39, 4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 1, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 1, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 0, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b0001, 4'b0000, 7'd19, 7'd83, 0, 0, 7'd0,  4'b0001, 0, 1, 7'd43));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 0, 1, 7'd25, 4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 0, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 1, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 1, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 0, 0, 7'd0,  4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd19, 7'd83, 0, 0, 7'd0,  4'b1111, 0, 1, 7'd54));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (OUT_grant !== e.grant) begin
        n_fail++; $display("FAIL branch[%0d] grant got %b want %b", i, OUT_grant, e.grant);
      end
      n_chk++;
      if (OUT_stall !== e.stall) begin
        n_fail++; $display("FAIL branch[%0d] stall got %b want %b", i, OUT_stall, e.stall);
      end
      for (int l = 0; l < 4; l++) if (e.grant[l]) begin
        n_chk++;
        if (OUT_sqN[l] !== e.sqn[l]) begin
          n_fail++; $display("FAIL branch[%0d] sqN%0d got %0d want %0d", i, l, OUT_sqN[l], e.sqn[l]);
        end
      end
      @(posedge clk); #1;
      if (st[i].cf) begin
        n_chk++;
        if (OUT_free !== st[i].ef) begin
          n_fail++; $display("FAIL branch[%0d] free got %0d want %0d", i, OUT_free, st[i].ef);
        end
      end
    end
  endtask

  // SqN wrap 127 -> 0, free-count saturation, then reset out of SER_WAIT.
  task automatic test_wrap_and_reset();
    step_t st[$];
    exp_t  e;
    st.push_back(mk(0, 4'b0000, 4'b0000, 7'd0, 7'd1,   0, 1, 7'd126, 4'b0000, 0, 0, 7'd0));
    st.push_back(mk(0, 4'b0000, 4'b0000, 7'd0, 7'd1,   0, 0, 7'd0,   4'b0000, 0, 0, 7'd0));
    st.push_back(mk(0, 4'b0000, 4'b0000, 7'd0, 7'd1,   0, 0, 7'd0,   4'b0000, 0, 0, 7'd0));
    st.push_back(mk(0, 4'b0011, 4'b0000, 7'd0, 7'd1,   0, 0, 7'd0,   4'b0011, 0, 1, 7'd1));
    st.push_back(mk(0, 4'b0000, 4'b0000, 7'd0, 7'd100, 0, 0, 7'd0,   4'b0000, 0, 1, 7'd64));
    st.push_back(mk(0, 4'b0001, 4'b0000, 7'd0, 7'd100, 0, 0, 7'd0,   4'b0001, 0, 1, 7'd64));
    st.push_back(mk(0, 4'b0001, 4'b0001, 7'd0, 7'd100, 0, 0, 7'd0,   4'b0000, 1, 0, 7'd0));
    st.push_back(mk(1, 4'b0001, 4'b0001, 7'd0, 7'd100, 0, 1, 7'd70,  4'b0000, 1, 1, 7'd64));
    st.push_back(mk(0, 4'b0001, 4'b0001, 7'd0, 7'd63,  0, 0, 7'd0,   4'b0001, 0, 1, 7'd63));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd0, 7'd63,  0, 0, 7'd0,   4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd1, 7'd63,  0, 0, 7'd0,   4'b0000, 1, 0, 7'd0));
    st.push_back(mk(0, 4'b1111, 4'b0000, 7'd1, 7'd63,  0, 0, 7'd0,   4'b1111, 0, 1, 7'd59));
    foreach (st[i]) begin
      apply(st[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_chk++;
      if (OUT_grant !== e.grant) begin
        n_fail++; $display("FAIL wrap[%0d] grant got %b want %b", i, OUT_grant, e.grant);
      end
      n_chk++;
      if (OUT_stall !== e.stall) begin
        n_fail++; $display("FAIL wrap[%0d] stall got %b want %b", i, OUT_stall, e.stall);
      end
      for (int l = 0; l < 4; l++) if (e.grant[l]) begin
        n_chk++;
        if (OUT_sqN[l] !== e.sqn[l]) begin
          n_fail++; $display("FAIL wrap[%0d] sqN%0d got %0d want %0d", i, l, OUT_sqN[l], e.sqn[l]);
        end
      end
      @(posedge clk); #1;
      if (st[i].cf) begin
        n_chk++;
        if (OUT_free !== st[i].ef) begin
          n_fail++; $display("FAIL wrap[%0d] free got %0d want %0d", i, OUT_free, st[i].ef);
        end
      end
    end
  endtask

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    model_next      = 7'd0;
    rst             = 1'b1;
    IN_req          = '0;
    IN_reqSerialize = '0;
    IN_curSqN       = '0;
    IN_maxSqN       = 7'd63;
    IN_mispredFlush = 1'b0;
    IN_branch       = '{taken: 1'b0, sqN: 7'd0, flush: 1'b0};
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_full();
    test_serialize();
    test_ser_lane2();
    test_branch();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
